// File: rtl/tick_gen_if.sv
// Bundle of the tick_gen control inputs, divisors, outputs and per-channel count visibility.
// The block has no handshake: inputs are sampled every rising edge, outputs are flop-driven.
interface tick_gen_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 20
);
    logic                    en;
    logic                    clr;
    logic [N_CH*CNT_W-1:0]   div_i;
    logic [N_CH-1:0]         tick_o;
    logic [N_CH-1:0]         sq_o;
    // Live channel counters, packed like div_i, for observation only.
    logic [N_CH*CNT_W-1:0]   cnt;

    modport master (
        output en, clr, div_i,
        input  tick_o, sq_o, cnt
    );

    modport slave (
        input  en, clr, div_i,
        output tick_o, sq_o, cnt
    );
endinterface

// File: rtl/tick_gen.sv
// Multi-channel programmable tick divider with optional square-wave outputs.
// Define TICK_GEN_SQ_EN to build the square-wave flops; otherwise sq_o is tied to 0.
module tick_gen #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 20
) (
    input  logic      clk,
    input  logic      rst,
    tick_gen_if.slave bus
);

    logic [CNT_W-1:0] div_s [N_CH];
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  tick_q;
    logic [N_CH-1:0]  tick_d;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch_io
        assign div_s[g]                       = bus.div_i[g*CNT_W +: CNT_W];
        assign bus.cnt[g*CNT_W +: CNT_W]      = cnt_q[g];
    end

    // A divisor of 0 parks the channel; comparing against D-1 lets a shrunk
    // divisor wrap immediately instead of running the counter up to overflow.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i]  = cnt_q[i];
            tick_d[i] = 1'b0;
            if (bus.en) begin
                if (div_s[i] == '0) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] >= div_s[i] - CNT_W'(1)) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
            tick_q <= '0;
        end else if (bus.clr) begin
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
            tick_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
            tick_q <= tick_d;
        end
    end

    assign bus.tick_o = tick_q;

`ifdef TICK_GEN_SQ_EN
    logic [N_CH-1:0] sq_q;

    // Toggling on every tick load gives a 50% duty wave of period 2*D.
    always_ff @(posedge clk) begin
        if (rst) begin
            sq_q <= '0;
        end else if (bus.clr) begin
            sq_q <= '0;
        end else begin
            sq_q <= sq_q ^ tick_d;
        end
    end

    assign bus.sq_o = sq_q;
`else
    assign bus.sq_o = '0;
`endif

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen: a 2-channel 20-bit instance and a 1-channel 4-bit instance.
// Square-wave expectations follow TICK_GEN_SQ_EN (stuck at 0 when it is undefined).
module tb_tick_gen;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    logic sq0_exp, sq1_exp, sqb_exp;

`ifdef TICK_GEN_SQ_EN
    localparam bit SQ = 1'b1;
`else
    localparam bit SQ = 1'b0;
`endif

    always #5 clk = ~clk;

    tick_gen_if #(.N_CH(2), .CNT_W(20)) ifa ();
    tick_gen_if #(.N_CH(1), .CNT_W(4))  ifb ();

    tick_gen #(.N_CH(2), .CNT_W(20)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    tick_gen #(.N_CH(1), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ch1 always runs with D=1, so its counter stays 0 and it ticks on every enabled edge.
    task automatic check_a(input string tag, input bit t0, input logic [31:0] c0, input bit t1);
        if (t0) sq0_exp = ~sq0_exp;
        if (t1) sq1_exp = ~sq1_exp;
        chk({tag, ".tick0"}, 32'(ifa.tick_o[0]), 32'(t0));
        chk({tag, ".tick1"}, 32'(ifa.tick_o[1]), 32'(t1));
        chk({tag, ".cnt0"},  32'(ifa.cnt[19:0]), c0);
        chk({tag, ".cnt1"},  32'(ifa.cnt[39:20]), 32'd0);
        chk({tag, ".sq0"},   32'(ifa.sq_o[0]), 32'(SQ & sq0_exp));
        chk({tag, ".sq1"},   32'(ifa.sq_o[1]), 32'(SQ & sq1_exp));
    endtask

    task automatic check_zero_a(input string tag);
        sq0_exp = 1'b0;
        sq1_exp = 1'b0;
        check_a(tag, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic check_b(input string tag, input bit t, input logic [31:0] c);
        if (t) sqb_exp = ~sqb_exp;
        chk({tag, ".tick"}, 32'(ifb.tick_o[0]), 32'(t));
        chk({tag, ".cnt"},  32'(ifb.cnt), c);
        chk({tag, ".sq"},   32'(ifb.sq_o[0]), 32'(SQ & sqb_exp));
    endtask

    // ch0 counting from 0 with divisor d, en=1, for n edges.
    task automatic expect_ch0(input string tag, input int n, input int d);
        for (int c = 1; c <= n; c++) begin
            step();
            check_a(tag, (c % d) == 0, 32'(c % d), 1'b1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        ifa.en    = 1'b0;
        ifa.clr   = 1'b0;
        ifa.div_i = {20'd1, 20'd4};
        ifb.en    = 1'b0;
        ifb.clr   = 1'b0;
        ifb.div_i = 4'd15;
        sq0_exp   = 1'b0;
        sq1_exp   = 1'b0;
        sqb_exp   = 1'b0;

        step();
        step();
        check_zero_a("reset");
        check_b("reset_b", 1'b0, 32'd0);

        // ch0 D=4 ticks on edges 4, 8, 12; ch1 D=1 ticks from edge 1.
        rst    = 1'b0;
        ifa.en = 1'b1;
        expect_ch0("basic", 12, 4);

        // clr mid-period with en=1.
        step(); check_a("pre_clr1", 1'b0, 32'd1, 1'b1);
        step(); check_a("pre_clr2", 1'b0, 32'd2, 1'b1);
        ifa.clr = 1'b1;
        step(); check_zero_a("clr_mid");
        ifa.clr = 1'b0;
        expect_ch0("after_clr", 8, 4);

        // rst mid-period.
        step(); check_a("pre_rst1", 1'b0, 32'd1, 1'b1);
        step(); check_a("pre_rst2", 1'b0, 32'd2, 1'b1);
        rst = 1'b1;
        step(); check_zero_a("rst_mid");
        rst = 1'b0;
        expect_ch0("after_rst", 4, 4);

        // rst and clr together behave as rst.
        step(); check_a("pre_rc1", 1'b0, 32'd1, 1'b1);
        step(); check_a("pre_rc2", 1'b0, 32'd2, 1'b1);
        rst     = 1'b1;
        ifa.clr = 1'b1;
        step(); check_zero_a("rst_clr");
        rst     = 1'b0;
        ifa.clr = 1'b0;
        expect_ch0("after_rst_clr", 4, 4);

        // D=10 to cnt=7, then shrink to 5: immediate tick then every 5.
        ifa.div_i[19:0] = 20'd10;
        expect_ch0("d10", 7, 10);
        ifa.div_i[19:0] = 20'd5;
        step(); check_a("shrink", 1'b1, 32'd0, 1'b1);
        expect_ch0("d5", 10, 5);

        // Grow 3 -> 6 at cnt=1: keeps counting to 5, then ticks.
        ifa.div_i[19:0] = 20'd3;
        step(); check_a("grow0", 1'b0, 32'd1, 1'b1);
        ifa.div_i[19:0] = 20'd6;
        for (int c = 2; c <= 5; c++) begin
            step(); check_a("grow", 1'b0, 32'(c), 1'b1);
        end
        step(); check_a("grow_tick", 1'b1, 32'd0, 1'b1);

        // D=3, pause at cnt=1 for 4 edges; tick 2 enabled edges after resume.
        ifa.div_i[19:0] = 20'd3;
        step(); check_a("pause0", 1'b0, 32'd1, 1'b1);
        ifa.en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step(); check_a("pause", 1'b0, 32'd1, 1'b0);
        end
        ifa.en = 1'b1;
        step(); check_a("resume1", 1'b0, 32'd2, 1'b1);
        step(); check_a("resume2", 1'b1, 32'd0, 1'b1);

        // Square wave with D=3 from a clean start: high 3, low 3.
        ifa.clr = 1'b1;
        step(); check_zero_a("sq_clr");
        ifa.clr = 1'b0;
        expect_ch0("sq_d3", 12, 3);
        ifa.en = 1'b0;

        // 4-bit instance: all-ones divisor, then D=0 parks the channel.
        ifb.en = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step(); check_b("b_d15", (c % 15) == 0, 32'(c % 15));
        end
        for (int c = 1; c <= 3; c++) begin
            step(); check_b("b_pre0", 1'b0, 32'(c));
        end
        ifb.div_i = 4'd0;
        for (int c = 0; c < 20; c++) begin
            step(); check_b("b_d0", 1'b0, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
